// File: rtl/ram_arb_pkg.sv
// Shared constants for the program/data RAM arbiter: FSM state encoding and
// requester port indices.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WAIT   = 2'b10,
    ACK    = 2'b11
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select for the RAM arbiter. Tie policy is fixed CPU
// priority unless RAM_ARB_ROUND_ROBIN_EN is defined (alternate against owner).
module ram_arb_pick (
  input  logic cpuReq,
  input  logic ldrReq,
  input  logic holdActive,
  input  logic holdPort,
  input  logic owner,
  output logic grantValid,
  output logic grantPort
);
  import ram_arb_pkg::*;

  logic tieWinner;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  assign tieWinner = ~owner;
`else
  logic unusedOwner;
  assign tieWinner   = PORT_CPU;
  assign unusedOwner = owner;
`endif

  // An active holder has its req high by construction, so it wins outright.
  always_comb begin
    grantValid = 1'b0;
    grantPort  = PORT_CPU;
    if (holdActive) begin
      grantValid = 1'b1;
      grantPort  = holdPort;
    end else if (cpuReq && ldrReq) begin
      grantValid = 1'b1;
      grantPort  = tieWinner;
    end else if (cpuReq) begin
      grantValid = 1'b1;
      grantPort  = PORT_CPU;
    end else if (ldrReq) begin
      grantValid = 1'b1;
      grantPort  = PORT_LDR;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between CPU sequencer and program loader: four-cycle
// req/ack accesses with optional lock. Tie policy selectable via RAM_ARB_ROUND_ROBIN_EN.
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic              ldr_lock,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              owner,
  output logic              busy
);
  import ram_arb_pkg::*;

  state_t            state, nextState;
  logic              accWe;
  logic              holdValid, holdPort, holdActive;
  logic              holderReq, holderLock;
  logic              grantValid, grantPort;
  logic              selWe, selLock;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  // A holder only keeps priority while it is still asking and still locking.
  assign holderReq  = holdPort ? ldr_req  : cpu_req;
  assign holderLock = holdPort ? ldr_lock : cpu_lock;
  assign holdActive = holdValid & holderReq & holderLock;

  assign selWe    = grantPort ? ldr_we    : cpu_we;
  assign selAddr  = grantPort ? ldr_addr  : cpu_addr;
  assign selWdata = grantPort ? ldr_wdata : cpu_wdata;
  assign selLock  = owner     ? ldr_lock  : cpu_lock;

  ram_arb_pick uPick (
    .cpuReq     (cpu_req),
    .ldrReq     (ldr_req),
    .holdActive (holdActive),
    .holdPort   (holdPort),
    .owner      (owner),
    .grantValid (grantValid),
    .grantPort  (grantPort)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (grantValid) nextState = ACCESS;
      ACCESS:  nextState = WAIT;
      WAIT:    nextState = ACK;
      ACK:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      owner     <= PORT_CPU;
      busy      <= 1'b0;
      accWe     <= 1'b0;
      holdValid <= 1'b0;
      holdPort  <= PORT_CPU;
    end else begin
      case (state)
        IDLE: begin
          // Release and normal arbitration happen on the same edge.
          if (holdValid && !holdActive) holdValid <= 1'b0;
          if (grantValid) begin
            owner     <= grantPort;
            ram_addr  <= selAddr;
            ram_wdata <= selWdata;
            ram_we    <= selWe;
            ram_re    <= ~selWe;
            accWe     <= selWe;
            busy      <= 1'b1;
          end
        end
        ACCESS: begin
          ram_we <= 1'b0;
          ram_re <= 1'b0;
        end
        WAIT: begin
          // Synchronous RAM data from the strobe cycle is valid here.
          if (owner == PORT_LDR) begin
            ldr_ack <= 1'b1;
            if (!accWe) ldr_rdata <= ram_rdata;
          end else begin
            cpu_ack <= 1'b1;
            if (!accWe) cpu_rdata <= ram_rdata;
          end
          if (selLock) begin
            holdValid <= 1'b1;
            holdPort  <= owner;
          end
        end
        ACK: begin
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
